// File: rtl/uart_button_sender_pkg.sv
// uart_button_pkg: shared constants and the TX state encoding for
// uart_button_sender.
// Optional build macro UART_PARITY_EN adds the PARITY state (8E1 frames).
package uart_button_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEF     = 50_000_000;
  localparam int unsigned BAUD_RATE_DEF       = 115_200;
  localparam int unsigned CLKS_PER_BIT_DEF    = CLK_FREQ_HZ_DEF / BAUD_RATE_DEF;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  localparam logic [7:0] FIRST_CHAR = 8'h30;
  localparam logic [7:0] LAST_CHAR  = 8'h39;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_button_sender_serializer.sv
// uart_tx_serializer: TX-only UART framer (start, 8 data bits LSB first,
// optional even parity, stop). Each bit is held CLKS_PER_BIT clocks.
// Build macro UART_PARITY_EN: insert an even-parity bit after bit 7.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_start       request a frame; taken only while o_ready is high
//   i_data        byte to send, sampled with i_start
//   o_tx          registered serial line, idle high
//   o_busy        high from START entry to the end of STOP
//   o_ready       idle, or in the last clock of the stop bit
module uart_tx_serializer
  import uart_button_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_ready
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef UART_PARITY_EN
  logic          r_parity;
`endif
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == LAST_CNT);
  assign o_tx      = r_tx;
  assign o_busy    = (r_state != TX_IDLE);
  // Accepting a start in the last stop clock lets a queued frame follow
  // with no idle gap on the line.
  assign o_ready   = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= TX_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef UART_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (i_start) begin
            r_state  <= TX_START;
            r_tx     <= 1'b0;
            r_cnt    <= '0;
            r_shift  <= i_data;
`ifdef UART_PARITY_EN
            r_parity <= ^i_data;
`endif
          end
        end
        default: begin
          if (!w_bit_end) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            case (r_state)
              TX_START: begin
                r_state <= TX_DATA;
                r_bit   <= '0;
                r_tx    <= r_shift[0];
              end
              TX_DATA: begin
                if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                  r_state <= TX_PARITY;
                  r_tx    <= r_parity;
`else
                  r_state <= TX_STOP;
                  r_tx    <= 1'b1;
`endif
                end else begin
                  r_bit   <= r_bit + 3'd1;
                  r_shift <= r_shift >> 1;
                  r_tx    <= r_shift[1];
                end
              end
`ifdef UART_PARITY_EN
              TX_PARITY: begin
                r_state <= TX_STOP;
                r_tx    <= 1'b1;
              end
`endif
              TX_STOP: begin
                if (i_start) begin
                  r_state  <= TX_START;
                  r_tx     <= 1'b0;
                  r_shift  <= i_data;
`ifdef UART_PARITY_EN
                  r_parity <= ^i_data;
`endif
                end else begin
                  r_state <= TX_IDLE;
                  r_tx    <= 1'b1;
                end
              end
              default: begin
                r_state <= TX_IDLE;
                r_tx    <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_button_sender.sv
// uart_button_sender: each debounced press of KEY sends the next ASCII digit
// ('0'..'9', wrapping) over a TX-only UART; LED shows the last code sent.
// Build macro UART_PARITY_EN: 8E1 frames instead of 8N1.
// Ports:
//   CLOCK_50  system clock
//   reset     asynchronous active-high reset
//   KEY       push-button, active-low, asynchronous
//   SW        reserved, ignored
//   LED       last transmitted character code
//   UART_TX   serial output, idle high
module uart_button_sender #(
  parameter int unsigned CLK_FREQ_HZ     = uart_button_pkg::CLK_FREQ_HZ_DEF,
  parameter int unsigned BAUD_RATE       = uart_button_pkg::BAUD_RATE_DEF,
  parameter int unsigned CLKS_PER_BIT    = CLK_FREQ_HZ / BAUD_RATE,
  parameter logic [7:0]  FIRST_CHAR      = uart_button_pkg::FIRST_CHAR,
  parameter logic [7:0]  LAST_CHAR       = uart_button_pkg::LAST_CHAR,
  parameter int unsigned DEBOUNCE_CYCLES = uart_button_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       KEY,
  input  logic [3:0] SW,
  output logic [7:0] LED,
  output logic       UART_TX
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [DW-1:0] r_db_cnt;
  logic          r_press;
  logic          r_pending;
  logic [7:0]    r_next_char;
  logic [7:0]    r_led;
  logic          w_ready;
  logic          w_busy;
  logic          w_fire;
  logic          w_unused_sw;

  assign w_unused_sw = ^SW;
  assign LED         = r_led;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], KEY};
    end
  end

  // A new level is accepted after DEBOUNCE_CYCLES consecutive samples that
  // differ from the accepted one; any bounce back restarts the count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_stable <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt <= '0;
        r_stable <= r_sync[1];
        r_press  <= ~r_sync[1];
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_fire = w_ready & (r_pending | r_press);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_next_char <= FIRST_CHAR;
      r_led       <= '0;
    end else if (w_fire) begin
      r_led       <= r_next_char;
      r_next_char <= (r_next_char == LAST_CHAR) ? FIRST_CHAR : r_next_char + 8'd1;
      r_pending   <= 1'b0;
    end else if (r_press && w_busy) begin
      r_pending <= 1'b1;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_start (w_fire),
    .i_data  (r_next_char),
    .o_tx    (UART_TX),
    .o_busy  (w_busy),
    .o_ready (w_ready)
  );

endmodule

// File: tb/tb_uart_button_sender.sv
module tb_uart_button_sender;

  localparam int unsigned CPB   = 40;
  localparam int unsigned CLK_T = 20;
  localparam int unsigned BIT_T = CPB * CLK_T;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       KEY;
  logic [3:0] SW;
  logic [7:0] LED;
  logic       UART_TX;

  typedef struct {
    logic [7:0] data;
    logic       start_ok;
    logic       par;
    logic       stop_ok;
    time        ts;
  } frame_t;

  frame_t q[$];
  time    first_rise;
  time    t_key;
  int     n_tests = 0;
  int     n_fail  = 0;

  uart_button_sender #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .KEY      (KEY),
    .SW       (SW),
    .LED      (LED),
    .UART_TX  (UART_TX)
  );

  always #(CLK_T / 2) CLOCK_50 = ~CLOCK_50;

  always @(posedge UART_TX) if (first_rise == 0) first_rise = $time;

  // Line receiver: samples each bit 10 ticks past its midpoint.
  initial begin
    frame_t f;
    forever begin
      @(negedge UART_TX);
      f.ts = $time;
      first_rise = 0;
      #(BIT_T / 2 + 10);
      f.start_ok = (UART_TX == 1'b0);
      for (int i = 0; i < 8; i++) begin
        #(BIT_T);
        f.data[i] = UART_TX;
      end
      f.par = 1'b0;
`ifdef UART_PARITY_EN
      #(BIT_T);
      f.par = UART_TX;
`endif
      #(BIT_T);
      f.stop_ok = (UART_TX == 1'b1);
      q.push_back(f);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int low_t, input int high_t);
    @(negedge CLOCK_50);
    KEY = 1'b0;
    t_key = $time;
    #(low_t);
    KEY = 1'b1;
    #(high_t);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (q.size() < n && k < 20000) begin
      @(negedge CLOCK_50);
      k++;
    end
    check(tag, 64'(q.size()), 64'(n));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp, output time ts);
    frame_t f;
    ts = 0;
    if (q.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      f = q.pop_front();
      ts = f.ts;
      check({tag, "_data"}, 64'(f.data), 64'(exp));
      check({tag, "_start"}, 64'(f.start_ok), 64'd1);
      check({tag, "_stop"}, 64'(f.stop_ok), 64'd1);
`ifdef UART_PARITY_EN
      check({tag, "_par"}, 64'(f.par), 64'(^exp));
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2, ts;
    logic [7:0] seq [10];
    reset = 1'b1;
    KEY   = 1'b1;
    SW    = 4'h0;

    // Reset values, then an idle line.
    #100;
    check("rst_tx", 64'(UART_TX), 64'd1);
    check("rst_led", 64'(LED), 64'h00);
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1000;
      SW = 4'(i * 5 + 3);
      check("idle_tx", 64'(UART_TX), 64'd1);
    end
    check("idle_led", 64'(LED), 64'h00);
    check("idle_noframe", 64'(q.size()), 64'd0);

    // Single press: '0', start latency, bit period.
    press(1000, 1000);
    wait_frames(1, "t2_wait");
    ts = (q.size() > 0) ? q[0].ts : 0;
    check("t2_latency", 64'((ts - t_key) >= 300 && (ts - t_key) <= 1000), 64'd1);
    check("t2_bitper", 64'(first_rise - ts), 64'(5 * BIT_T));
    check_frame("t2", 8'h30, t1);
    check("t2_led", 64'(LED), 64'h30);

    // Ten more presses issued mid-stop-bit: '1'..'9' then wrap to '0'.
    seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
    for (int k = 0; k < 10; k++) begin
      press(1000, 1000);
      wait_frames(1, "t3_wait");
      check_frame("t3", seq[k], t1);
      check("t3_led", 64'(LED), 64'(seq[k]));
    end
    #10000;
    check("t3_noextra", 64'(q.size()), 64'd0);

    // Three presses inside one frame: one sent, one pending, one dropped.
    press(1000, 1000);
    press(1000, 1000);
    press(1000, 1000);
    wait_frames(2, "t4_wait");
    check_frame("t4a", 8'h31, t1);
    check_frame("t4b", 8'h32, t2);
    check("t4_b2b", 64'(t2 - t1), 64'(FRAME_BITS * BIT_T));
    #12000;
    check("t4_nothird", 64'(q.size()), 64'd0);

    // Reset in the middle of data bit 2 of '3'.
    @(negedge CLOCK_50);
    KEY = 1'b0;
    for (int k = 0; k < 2000 && UART_TX !== 1'b0; k++) @(negedge CLOCK_50);
    #(3 * BIT_T + BIT_T / 2);
    check("t5_midbit", 64'(UART_TX), 64'd0);
    check("t5_led3", 64'(LED), 64'h33);
    reset = 1'b1;
    #1;
    check("t5_rst_tx", 64'(UART_TX), 64'd1);
    check("t5_rst_led", 64'(LED), 64'h00);
    KEY = 1'b1;
    #100;
    @(negedge CLOCK_50);
    reset = 1'b0;
    #12000;
    q.delete();
    press(1000, 1000);
    wait_frames(1, "t5_wait");
    check_frame("t5", 8'h30, t1);

    // Bounce: 100-tick toggles for 2000 ticks, then steady low.
    #10000;
    q.delete();
    @(negedge CLOCK_50);
    for (int i = 0; i < 20; i++) begin
      KEY = ~KEY;
      SW  = ~SW;
      #100;
    end
    KEY = 1'b0;
    #2000;
    KEY = 1'b1;
    #1000;
    wait_frames(1, "t6_wait");
    check_frame("t6", 8'h31, t1);
    #12000;
    check("t6_single", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
